// File: rtl/mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_arbiter
// Description : Shares a single-ported unified I/D memory between the IF-stage
//               fetch port and the MEM-stage load/store port. One access is in
//               flight at a time; data has priority, bounded by an
//               anti-starvation counter so fetch always makes progress.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              owner_d;     // 1 = data port owns the access
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [3:0]        lat_cnt;
  logic [3:0]        starve_cnt;
  logic              grant_if;
  logic              grant_d;

  // Arbitration and next state; grants are gated by rst_n so nothing is
  // accepted (or shown as accepted) while reset is held.
  always_comb begin
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rst_n) begin
          if (d_req && if_req) begin
            if (starve_cnt == STARVE_LIM) grant_if = 1'b1;
            else                          grant_d  = 1'b1;
          end else if (d_req) begin
            grant_d = 1'b1;
          end else if (if_req) begin
            grant_if = 1'b1;
          end
        end
        if (grant_if || grant_d) state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (lat_cnt == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, request latches, latency/starvation counters, responses.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_cnt    <= 4'd0;
      starve_cnt <= 4'd0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
    end else begin
      state     <= state_nxt;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner_d   <= 1'b1;
            lat_we    <= d_we;
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
          end else if (grant_if) begin
            owner_d   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= if_addr;
            lat_wdata <= '0;
          end
          // Fetch progress or an absent fetch request resets the fairness debt
          if (grant_if || !if_req) begin
            starve_cnt <= 4'd0;
          end else if (grant_d && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end
        ISSUE: lat_cnt <= LAT_INIT;
        WAIT: begin
          if (lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 4'd1;
          end else if (owner_d) begin
            d_rvalid <= 1'b1;
            d_rdata  <= lat_we ? '0 : mem_rdata;
          end else begin
            if_rvalid <= 1'b1;
            if_rdata  <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign mem_en    = (state == ISSUE);
  assign mem_we    = (state == ISSUE) && lat_we;
  assign mem_addr  = (state == ISSUE) ? lat_addr  : '0;
  assign mem_wdata = (state == ISSUE) ? lat_wdata : '0;
  assign busy      = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_mem_arbiter
// Description : Bench for mips_mem_arbiter; one instance at MEM_LAT=1 and one
//               at MEM_LAT=3 share the request inputs, each with its own
//               memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_mem_arbiter;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [9:0]  if_addr, d_addr;
  logic [31:0] d_wdata;

  logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_en1, mem_we1, busy1;
  logic [31:0] if_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
  logic [9:0]  mem_addr1;
  logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3, busy3;
  logic [31:0] if_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
  logic [9:0]  mem_addr3;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] exp_if1[$];
  logic [31:0] exp_d1[$];
  logic [31:0] exp_if3[$];

  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;

  mips_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk1(clk1), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  mips_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk1(clk1), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Initial memory image
  function automatic logic [31:0] memval(input int a);
    if (a == 0) return 32'h28010078;
    return (32'(a) * 32'h00013579) ^ 32'h3C000000;
  endfunction

  // Memory models: writes overlay the initial image; reads are pipelined
  logic [31:0] wm1 [0:1023];
  logic [31:0] wm3 [0:1023];
  bit   [1023:0] wv1;
  bit   [1023:0] wv3;
  logic [31:0] p1, p3a, p3b, p3c;

  always @(posedge clk1) begin
    if (mem_en1 && mem_we1) begin
      wm1[mem_addr1] <= mem_wdata1;
      wv1[mem_addr1] <= 1'b1;
    end
    p1 <= wv1[mem_addr1] ? wm1[mem_addr1] : memval(int'(mem_addr1));
    if (mem_en3 && mem_we3) begin
      wm3[mem_addr3] <= mem_wdata3;
      wv3[mem_addr3] <= 1'b1;
    end
    p3a <= wv3[mem_addr3] ? wm3[mem_addr3] : memval(int'(mem_addr3));
    p3b <= p3a;
    p3c <= p3b;
  end
  assign mem_rdata1 = p1;
  assign mem_rdata3 = p3c;

  task automatic tick;
    @(posedge clk1);
    #2;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    if_addr = 10'd0; d_addr = 10'd0; d_wdata = 32'hFFFF_FFFF;
    tick; tick;
    vectors++;
    if ({if_gnt1, if_rvalid1, if_rdata1, d_gnt1, d_rvalid1, d_rdata1, mem_en1, mem_we1,
         mem_addr1, mem_wdata1, busy1} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs_lat1: busy=%b gnt=%b%b mem_en=%b rdata=%h/%h, required all 0",
               busy1, if_gnt1, d_gnt1, mem_en1, if_rdata1, d_rdata1);
    end
    vectors++;
    if ({if_gnt3, if_rvalid3, if_rdata3, d_gnt3, d_rvalid3, d_rdata3, mem_en3, mem_we3,
         mem_addr3, mem_wdata3, busy3} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs_lat3: busy=%b gnt=%b%b mem_en=%b, required all 0",
               busy3, if_gnt3, d_gnt3, mem_en3);
    end
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    tick;
    rst_n = 1'b1;
    tick; tick;
  endtask

  task automatic test_fetch;
    tick;
    if_req = 1'b1; if_addr = 10'd0; #1;
    exp_if1.push_back(32'h28010078);
    vectors++;
    if ({if_gnt1, d_gnt1} !== 2'b10) begin
      miscompares++;
      $display("FAIL fetch_gnt: got if/d gnt=%b%b, required 10", if_gnt1, d_gnt1);
    end
    tick; if_req = 1'b0;
    vectors++;
    if ({mem_en1, mem_we1, mem_addr1, busy1} !== {1'b1, 1'b0, 10'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL fetch_issue: got en=%b we=%b addr=%0d busy=%b, required 1 0 0 1",
               mem_en1, mem_we1, mem_addr1, busy1);
    end
    tick;
    vectors++;
    if ({mem_en1, busy1, if_rvalid1} !== 3'b010) begin
      miscompares++;
      $display("FAIL fetch_wait: got en=%b busy=%b rvalid=%b, required 0 1 0", mem_en1, busy1, if_rvalid1);
    end
    tick;
    vectors++;
    if (if_rvalid1 !== 1'b1 || busy1 !== 1'b0 || exp_if1.size() == 0 || if_rdata1 !== exp_if1[0]) begin
      miscompares++;
      $display("FAIL fetch_rvalid: got rvalid=%b busy=%b rdata=%h, required 1 0 28010078",
               if_rvalid1, busy1, if_rdata1);
    end
    if (exp_if1.size() > 0) void'(exp_if1.pop_front());
    tick;
    vectors++;
    if (if_rvalid1 !== 1'b0 || if_rdata1 !== 32'h28010078) begin
      miscompares++;
      $display("FAIL fetch_hold: got rvalid=%b rdata=%h, required 0 28010078", if_rvalid1, if_rdata1);
    end
  endtask

  task automatic d_txn1(input logic we, input logic [9:0] a, input logic [31:0] wd,
                        input logic [31:0] exp);
    int n;
    logic [31:0] e;
    exp_d1.push_back(exp);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; #1;
    n = 0;
    while (d_gnt1 !== 1'b1 && n < 20) begin tick; n++; end
    vectors++;
    if (n >= 20) begin
      miscompares++;
      $display("FAIL d_gnt_timeout: got no d_gnt in 20 cycles, required a grant");
    end
    tick;
    d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    vectors++;
    if ({mem_en1, mem_we1, mem_addr1, mem_wdata1} !== {1'b1, we, a, wd}) begin
      miscompares++;
      $display("FAIL d_issue: got en=%b we=%b addr=%0d wdata=%h, required 1 %b %0d %h",
               mem_en1, mem_we1, mem_addr1, mem_wdata1, we, a, wd);
    end
    n = 0;
    tick;
    while (d_rvalid1 !== 1'b1 && n < 20) begin
      vectors++;
      if (if_rvalid1 !== 1'b0) begin
        miscompares++;
        $display("FAIL d_txn_if_rvalid: got if_rvalid=%b, required 0", if_rvalid1);
      end
      tick; n++;
    end
    e = (exp_d1.size() > 0) ? exp_d1.pop_front() : 32'hDEAD_BEEF;
    vectors++;
    if (n !== 1 || d_rdata1 !== e || if_rvalid1 !== 1'b0) begin
      miscompares++;
      $display("FAIL d_rvalid: got wait=%0d rdata=%h if_rvalid=%b, required 1 %h 0",
               n, d_rdata1, if_rvalid1, e);
    end
    tick;
  endtask

  task automatic test_store_load;
    d_txn1(1'b1, 10'd121, 32'd85, 32'd0);
    d_txn1(1'b0, 10'd121, 32'd0, 32'd85);
  endtask

  task automatic test_simultaneous;
    int dc;
    logic [31:0] e;
    tick;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'd5; d_wdata = '0;
    if_req = 1'b1; if_addr = 10'd7; #1;
    exp_d1.push_back(memval(5));
    exp_if1.push_back(memval(7));
    vectors++;
    if ({d_gnt1, if_gnt1} !== 2'b10) begin
      miscompares++;
      $display("FAIL simul_first: got d/if gnt=%b%b, required 10", d_gnt1, if_gnt1);
    end
    tick; d_req = 1'b0;
    tick;
    tick;
    e = (exp_d1.size() > 0) ? exp_d1.pop_front() : 32'hDEAD_BEEF;
    vectors++;
    if (d_rvalid1 !== 1'b1 || d_rdata1 !== e || if_gnt1 !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_d_done: got d_rvalid=%b rdata=%h if_gnt=%b, required 1 %h 1",
               d_rvalid1, d_rdata1, if_gnt1, e);
    end
    dc = cyc;
    tick; if_req = 1'b0;
    tick;
    tick;
    e = (exp_if1.size() > 0) ? exp_if1.pop_front() : 32'hDEAD_BEEF;
    vectors++;
    if (if_rvalid1 !== 1'b1 || if_rdata1 !== e || (cyc - dc) !== 3) begin
      miscompares++;
      $display("FAIL simul_if_done: got if_rvalid=%b rdata=%h gap=%0d, required 1 %h 3",
               if_rvalid1, if_rdata1, cyc - dc, e);
    end
    tick;
  endtask

  task automatic test_starvation;
    logic [5:0] seq;
    int n;
    seq = 6'b101111;   // bit g = 1 when grant g must go to the data port
    tick;
    if_req = 1'b1; if_addr = 10'd9; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd3; d_wdata = '0; #1;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      while (!(d_gnt1 === 1'b1 || if_gnt1 === 1'b1) && n < 20) begin tick; n++; end
      vectors++;
      if ({d_gnt1, if_gnt1} !== (seq[g] ? 2'b10 : 2'b01) || (g > 0 && n !== 2)) begin
        miscompares++;
        $display("FAIL starve_grant%0d: got d/if gnt=%b%b gap=%0d, required %b gap 2",
                 g, d_gnt1, if_gnt1, n, seq[g] ? 2'b10 : 2'b01);
      end
      tick;
      if (g == 5) begin if_req = 1'b0; d_req = 1'b0; end
    end
    tick; tick; tick;
  endtask

  task automatic test_reset_mid;
    int gc, n;
    logic [31:0] e;
    tick;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'd4; #1;
    vectors++;
    if (d_gnt1 !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_gnt: got d_gnt=%b, required 1", d_gnt1);
    end
    tick; d_req = 1'b0;
    tick;
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({if_gnt1, if_rvalid1, if_rdata1, d_gnt1, d_rvalid1, d_rdata1, mem_en1, mem_we1,
         mem_addr1, mem_wdata1, busy1} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_outputs: got busy=%b mem_en=%b d_rdata=%h if_rdata=%h, required all 0",
               busy1, mem_en1, d_rdata1, if_rdata1);
    end
    tick; tick;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      vectors++;
      if (d_rvalid1 !== 1'b0 || busy1 !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_no_rvalid: got d_rvalid=%b busy=%b, required 0 0", d_rvalid1, busy1);
      end
    end
    tick;
    if_req = 1'b1; if_addr = 10'd2; #1;
    exp_if1.push_back(memval(2));
    vectors++;
    if (if_gnt1 !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_fetch_gnt: got if_gnt=%b, required 1", if_gnt1);
    end
    gc = cyc;
    tick; if_req = 1'b0;
    n = 0;
    while (if_rvalid1 !== 1'b1 && n < 20) begin tick; n++; end
    e = (exp_if1.size() > 0) ? exp_if1.pop_front() : 32'hDEAD_BEEF;
    vectors++;
    if (if_rvalid1 !== 1'b1 || if_rdata1 !== e || (cyc - gc) !== 3) begin
      miscompares++;
      $display("FAIL rstmid_fetch: got rvalid=%b rdata=%h latency=%0d, required 1 %h 3",
               if_rvalid1, if_rdata1, cyc - gc, e);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int k, n, gprev;
    logic [31:0] e;
    for (int i = 0; i < 8; i++) tick;
    k = 0; n = 0; gprev = -1;
    if_req = 1'b1; if_addr = 10'd0; #1;
    while ((k < 8 || exp_if3.size() > 0) && n < 100) begin
      if (if_rvalid3 === 1'b1) begin
        e = (exp_if3.size() > 0) ? exp_if3.pop_front() : 32'hDEAD_BEEF;
        vectors++;
        if (if_rdata3 !== e) begin
          miscompares++;
          $display("FAIL b2b_rdata: got %h, required %h", if_rdata3, e);
        end
      end
      if (k < 8 && if_gnt3 === 1'b1) begin
        vectors++;
        if (gprev >= 0 && (cyc - gprev) !== 5) begin
          miscompares++;
          $display("FAIL b2b_spacing%0d: got %0d cycles, required 5", k, cyc - gprev);
        end
        gprev = cyc;
        exp_if3.push_back(memval(k));
        k++;
      end
      tick; n++;
      if_addr = 10'(k);
      if_req = (k < 8);
      #1;
    end
    vectors++;
    if (n >= 100 || k !== 8) begin
      miscompares++;
      $display("FAIL b2b_timeout: got %0d grants, %0d pending, required 8 and 0", k, exp_if3.size());
    end
    if_req = 1'b0;
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_store_load;
    test_simultaneous;
    test_starvation;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
